// File: rtl/pov_spi_tx_pkg.sv
// Shared frame constants, state encoding and packing helper for the POV SPI transmitter.
// The receiver imports the same widths, so both ends agree on the 74-bit frame layout.
package pov_spi_tx_pkg;

    localparam int PLAYER_W   = 15;
    localparam int VEC_W      = 11;
    localparam int FRAME_BITS = 2 * PLAYER_W + 4 * VEC_W;
    localparam int BIT_CNT_W  = 7;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    // Raw-bit ranges of the fixed-point formats carried in the frame.
    localparam logic [PLAYER_W-1:0] UQ6_9_MIN = '0;
    localparam logic [PLAYER_W-1:0] UQ6_9_MAX = '1;
    localparam logic [VEC_W-1:0]    SQ2_9_MIN = {1'b1, {(VEC_W-1){1'b0}}};
    localparam logic [VEC_W-1:0]    SQ2_9_MAX = {1'b0, {(VEC_W-1){1'b1}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } tx_state_e;

    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic [PLAYER_W-1:0] px,
        input logic [PLAYER_W-1:0] py,
        input logic [VEC_W-1:0]    fx,
        input logic [VEC_W-1:0]    fy,
        input logic [VEC_W-1:0]    vx,
        input logic [VEC_W-1:0]    vy
    );
        return {px, py, fx, fy, vx, vy};
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter timing each SPI phase; expire is high while the count sits at zero.
module spi_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/pov_spi_tx.sv
// SPI mode-0 master that serialises one 74-bit point-of-view frame MSB-first on SCLK, /SS, MOSI.
// Every output is a flop; phase lengths come from spi_phase_timer, reloaded on each state change.
module pov_spi_tx
    import pov_spi_tx_pkg::*;
#(
    parameter int HALF = 4,
    parameter int GAP  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [PLAYER_W-1:0] playerX,
    input  logic [PLAYER_W-1:0] playerY,
    input  logic [VEC_W-1:0]    facingX,
    input  logic [VEC_W-1:0]    facingY,
    input  logic [VEC_W-1:0]    vplaneX,
    input  logic [VEC_W-1:0]    vplaneY,
    output logic                busy,
    output logic                done,
    output logic                o_sclk,
    output logic                o_ss_n,
    output logic                o_mosi
);

    localparam int TW = $clog2(((HALF > GAP) ? HALF : GAP) + 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(HALF - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP - 1);

    tx_state_e               state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    sclk_q, sclk_d;
    logic                    ss_n_q, ss_n_d;
    logic                    mosi_q, mosi_d;
    logic                    timer_load;
    logic [TW-1:0]           timer_val;
    logic                    expire;

    spi_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timer_load),
        .load_val (timer_val),
        .expire   (expire)
    );

    // MOSI only moves on the edge that drops SCLK, so it is settled a full half-period before each rise.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        ss_n_d    = ss_n_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SETUP;
                    shift_d   = pack_frame(playerX, playerY, facingX, facingY, vplaneX, vplaneY);
                    bit_cnt_d = '0;
                    ss_n_d    = 1'b0;
                    mosi_d    = playerX[PLAYER_W-1];
                end
            end
            ST_SETUP, ST_LOW: begin
                if (expire) begin
                    state_d = ST_HIGH;
                    sclk_d  = 1'b1;
                end
            end
            ST_HIGH: begin
                if (expire) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d   = ST_LOW;
                        shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
                        mosi_d    = shift_q[FRAME_BITS-2];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (expire) begin
                    state_d = ST_GAP;
                    ss_n_d  = 1'b1;
                end
            end
            ST_GAP: begin
                if (expire) begin
                    state_d = ST_IDLE;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sclk_d  = 1'b0;
                ss_n_d  = 1'b1;
                mosi_d  = 1'b0;
            end
        endcase
        busy_d     = (state_d != ST_IDLE);
        timer_load = (state_d != state_q);
        timer_val  = (state_d == ST_GAP) ? GAP_LOAD : HALF_LOAD;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            ss_n_q    <= ss_n_d;
            mosi_q    <= mosi_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign o_sclk = sclk_q;
    assign o_ss_n = ss_n_q;
    assign o_mosi = mosi_q;

endmodule

// File: tb/tb_pov_spi_tx.sv
// Self-checking bench for pov_spi_tx: a behavioural SPI receiver model captures frames,
// which are compared with randomly generated 74-bit frames and the frame timing formulas.
module tb_pov_spi_tx;

    localparam int HALF     = 2;
    localparam int GAP      = 2;
    localparam int SS_LOW   = 149 * HALF;
    localparam int FRAME_CY = 149 * HALF + GAP + 1;
    localparam int TIMEOUT  = 4000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [14:0] playerX = '0, playerY = '0;
    logic [10:0] facingX = '0, facingY = '0, vplaneX = '0, vplaneY = '0;
    logic        busy, done, o_sclk, o_ss_n, o_mosi;

    int n_checks = 0;
    int n_pass   = 0;

    pov_spi_tx #(.HALF(HALF), .GAP(GAP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .playerX (playerX),
        .playerY (playerY),
        .facingX (facingX),
        .facingY (facingY),
        .vplaneX (vplaneX),
        .vplaneY (vplaneY),
        .busy    (busy),
        .done    (done),
        .o_sclk  (o_sclk),
        .o_ss_n  (o_ss_n),
        .o_mosi  (o_mosi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: shift MOSI on each SCLK rise while /SS is low, keep only complete 74-bit frames.
    logic [73:0] rx_shift = '0;
    logic [73:0] rx_q[$];
    int   rx_bits = 0, last_rx_bits = 0;
    int   ss_low_cnt = 0, last_ss_low = 0;
    int   ss_high_run = 0, last_ss_high = 0;
    int   mosi_viol = 0, done_cnt = 0, done_cyc = 0;
    logic prev_sclk = 1'b0, prev_mosi = 1'b0, prev_ss = 1'b1;

    always @(negedge clk) begin
        if (o_ss_n === 1'b0) begin
            if (prev_ss) begin
                last_ss_high = ss_high_run;
                ss_high_run  = 0;
                ss_low_cnt   = 0;
                rx_bits      = 0;
            end
            ss_low_cnt++;
            if (o_sclk && !prev_sclk) begin
                rx_shift = {rx_shift[72:0], o_mosi};
                rx_bits++;
            end else if (o_sclk && prev_sclk && (o_mosi !== prev_mosi)) begin
                mosi_viol++;
            end
        end else begin
            if (!prev_ss) begin
                last_ss_low  = ss_low_cnt;
                last_rx_bits = rx_bits;
                if (rx_bits == 74) rx_q.push_back(rx_shift);
            end
            ss_high_run++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_sclk = o_sclk;
        prev_mosi = o_mosi;
        prev_ss   = o_ss_n;
    end

    int start_cyc = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [73:0] rand_frame();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[73:0];
    endfunction

    task automatic drive_vectors(input logic [73:0] f);
        playerX = f[73:59];
        playerY = f[58:44];
        facingX = f[43:33];
        facingY = f[32:22];
        vplaneX = f[21:11];
        vplaneY = f[10:0];
    endtask

    task automatic start_frame(input logic [73:0] f);
        drive_vectors(f);
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            start = ~start;
            tick();
            n_checks++;
            if ({o_ss_n, o_sclk, o_mosi, busy, done} !== 5'b10000) begin
                $display("[TB] FAIL reset_outputs: got {ss_n,sclk,mosi,busy,done}=%b want 10000", {o_ss_n, o_sclk, o_mosi, busy, done});
            end else n_pass++;
        end
        start = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_loopback();
        logic [73:0] f;
        bit ok;
        f = {15'h0300, 15'h0300, 11'h000, 11'h200, 11'h700, 11'h000};
        rx_q.delete();
        done_cnt = 0;
        start_frame(f);
        wait_done(ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL loopback_done: got no done within %0d cycles", TIMEOUT);
        else n_pass++;
        tick();
        n_checks++;
        if (last_rx_bits != 74) $display("[TB] FAIL loopback_sclk_rises: got %0d want 74", last_rx_bits);
        else n_pass++;
        n_checks++;
        if (rx_q.size() != 1) $display("[TB] FAIL loopback_frames: got %0d want 1", rx_q.size());
        else n_pass++;
        n_checks++;
        if (rx_q.size() == 0 || rx_q[0] !== f)
            $display("[TB] FAIL loopback_data: got %h want %h", (rx_q.size() != 0) ? rx_q[0] : 74'h0, f);
        else n_pass++;
    endtask

    task automatic test_timing();
        logic [73:0] f;
        bit ok;
        f = rand_frame();
        rx_q.delete();
        done_cnt  = 0;
        mosi_viol = 0;
        start_frame(f);
        n_checks++;
        if ({busy, o_ss_n} !== 2'b10) $display("[TB] FAIL timing_busy_after_start: got {busy,ss_n}=%b want 10", {busy, o_ss_n});
        else n_pass++;
        wait_done(ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL timing_done: got no done within %0d cycles", TIMEOUT);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("[TB] FAIL timing_busy_at_done: got %b want 0", busy);
        else n_pass++;
        n_checks++;
        if (done_cyc - start_cyc != FRAME_CY) $display("[TB] FAIL timing_done_latency: got %0d want %0d", done_cyc - start_cyc, FRAME_CY);
        else n_pass++;
        repeat (4) tick();
        n_checks++;
        if (last_ss_low != SS_LOW) $display("[TB] FAIL timing_ss_low: got %0d want %0d", last_ss_low, SS_LOW);
        else n_pass++;
        n_checks++;
        if (mosi_viol != 0) $display("[TB] FAIL timing_mosi_stable: got %0d changes want 0", mosi_viol);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1) $display("[TB] FAIL timing_done_pulses: got %0d want 1", done_cnt);
        else n_pass++;
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== f)
            $display("[TB] FAIL timing_data: got %h (n=%0d) want %h", (rx_q.size() != 0) ? rx_q[0] : 74'h0, rx_q.size(), f);
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        logic [73:0] fa, fb;
        bit ok;
        fa = rand_frame();
        fb = ~fa;
        rx_q.delete();
        done_cnt = 0;
        start_frame(fa);
        repeat (99) tick();
        drive_vectors(fb);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL busy_done: got no done within %0d cycles", TIMEOUT);
        else n_pass++;
        repeat (10) tick();
        n_checks++;
        if ({busy, o_ss_n} !== 2'b01) $display("[TB] FAIL busy_not_queued: got {busy,ss_n}=%b want 01", {busy, o_ss_n});
        else n_pass++;
        n_checks++;
        if (done_cnt != 1) $display("[TB] FAIL busy_done_pulses: got %0d want 1", done_cnt);
        else n_pass++;
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== fa)
            $display("[TB] FAIL busy_frame_unchanged: got %h (n=%0d) want %h", (rx_q.size() != 0) ? rx_q[0] : 74'h0, rx_q.size(), fa);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [73:0] fa, fb;
        bit ok;
        fa = rand_frame();
        fb = rand_frame();
        rx_q.delete();
        done_cnt = 0;
        start_frame(fa);
        wait_done(ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL b2b_first_done: got no done within %0d cycles", TIMEOUT);
        else n_pass++;
        start_frame(fb);
        n_checks++;
        if (last_ss_high != GAP + 1) $display("[TB] FAIL b2b_ss_high: got %0d want %0d", last_ss_high, GAP + 1);
        else n_pass++;
        wait_done(ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL b2b_second_done: got no done within %0d cycles", TIMEOUT);
        else n_pass++;
        repeat (4) tick();
        n_checks++;
        if (rx_q.size() != 2) $display("[TB] FAIL b2b_frames: got %0d want 2", rx_q.size());
        else n_pass++;
        n_checks++;
        if (rx_q.size() != 2 || rx_q[0] !== fa || rx_q[1] !== fb)
            $display("[TB] FAIL b2b_data: got %h want %h then %h", (rx_q.size() > 1) ? rx_q[1] : 74'h0, fa, fb);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [73:0] f1, f2;
        bit ok;
        f1 = rand_frame();
        f2 = rand_frame();
        rx_q.delete();
        start_frame(f1);
        ok = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (rx_bits >= 40) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!ok) $display("[TB] FAIL abort_reach_bit40: got %0d bits want 40", rx_bits);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({o_ss_n, o_sclk, busy} !== 3'b100) $display("[TB] FAIL abort_async_ss: got {ss_n,sclk,busy}=%b want 100", {o_ss_n, o_sclk, busy});
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (rx_q.size() != 0) $display("[TB] FAIL abort_discard: got %0d frames want 0", rx_q.size());
        else n_pass++;
        reset_n = 1'b1;
        tick();
        start_frame(f2);
        wait_done(ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL abort_next_done: got no done within %0d cycles", TIMEOUT);
        else n_pass++;
        repeat (4) tick();
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== f2)
            $display("[TB] FAIL abort_next_data: got %h (n=%0d) want %h", (rx_q.size() != 0) ? rx_q[0] : 74'h0, rx_q.size(), f2);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_timing();
        test_timing();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pov_spi_tx.md
# pov_spi_tx

SPI master transmitter that serialises one point-of-view frame (player position, facing vector and viewplane vector) onto a 3-wire SPI link (SCLK, /SS, MOSI). It is the host/test-side counterpart of the POV SPI receiver in the raybox-zero core. It drives a 74-bit, MSB-first, mode-0 frame whose edge timing is slow enough for the receiver's 2/3-stage input synchronisers. It sits in the FPGA host harness and the cocotb/loopback benches, between vector-generating logic and the core's `i_sclk`/`i_ss_n`/`i_mosi` pins.

## Interface
Parameters:
- `HALF`, default 4: clk cycles per SCLK half-period. Legal values are 2 and above.
- `GAP`, default 4: clk cycles /SS is held high after a frame. Legal values are 2 and above.

Ports (clock and reset first):
- `clk` input 1: single clock. All logic is on the rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request to send one frame. Sampled only in IDLE.
- `playerX`, `playerY` input 15 each: UQ6.9 raw bits.
- `facingX`, `facingY`, `vplaneX`, `vplaneY` input 11 each: SQ2.9 raw bits.
- `busy` output 1: high while a frame is in flight.
- `done` output 1: one-cycle pulse when a frame completes.
- `o_sclk`, `o_ss_n`, `o_mosi` output 1 each: SPI lines. All are registered, with no combinational path from any input.

## Operation
- Frame layout: the 74-bit frame is {playerX, playerY, facingX, facingY, vplaneX, vplaneY}. Bit 73 (playerX[14]) is sent first.
- Start: when `start`=1 in IDLE, the six vectors are latched into a 74-bit shift register and the FSM enters SETUP. Later input changes do not affect the frame in flight.
- States:
  - IDLE: `o_ss_n`=1, `o_sclk`=0, `o_mosi`=0.
  - SETUP: `o_ss_n`=0, `o_sclk`=0, `o_mosi`=bit73. Lasts HALF cycles, then goes to HIGH.
  - HIGH: `o_sclk`=1. Lasts HALF cycles. If the bit counter is 73, go to HOLD; otherwise go to LOW.
  - LOW: `o_sclk`=0. On entry, shift `o_mosi` to the next bit and increment the counter. Lasts HALF cycles, then goes to HIGH.
  - HOLD: `o_sclk`=0, `o_ss_n`=0. Lasts HALF cycles, then goes to GAP.
  - GAP: `o_ss_n`=1. Lasts GAP cycles, then returns to IDLE.
- Bit counter: 7 bits, covering 0..73. It never wraps within a frame.
- `start` while `busy`=1 is ignored. Nothing is queued.
- Abort: a reset mid-frame raises /SS at once. The receiver then discards the partial frame, because its bit counter clears while /SS is high.

## Timing
- Reset values: `busy`=0, `done`=0, `o_ss_n`=1, `o_sclk`=0, `o_mosi`=0. These take effect asynchronously on `reset_n` low, and the state is IDLE.
- `busy` and `o_ss_n`=0 are asserted in the cycle after `start` is accepted.
- /SS low duration: HALF + 148·HALF = 149·HALF cycles. This is 596 cycles at HALF=4.
- MOSI stability: MOSI is stable for at least HALF cycles before each SCLK rising edge and throughout the high phase. MOSI changes only on the clk edge that drops SCLK.
- Completion: at the end of GAP, the FSM enters IDLE with `done`=1 and `busy`=0 in the same cycle.
- Back-to-back frames: a `start` in that same cycle is accepted. The minimum frame period is therefore 149·HALF + GAP + 1 cycles.
- Receiver frequency requirement: the receiver clock must be at least the transmitter clk. With HALF and GAP both 2 or more, every SCLK phase and every /SS-high gap spans at least 2 receiver synchroniser samples.

## Structure
- Shared constants go in include `pov_frame_params.v`:
  - PLAYER_W=15
  - VEC_W=11
  - FRAME_BITS=74
  - the UQ6_9 and SQ2_9 range macros
- The receiver shares this include, so both ends agree on widths.
- One sub-module, `spi_phase_timer`: a loadable down-counter sized by $clog2(max(HALF,GAP)+1). It emits `expire` when the count reaches 0 and is reloaded on each state change.
- Everything else lives in `pov_spi_tx`: the FSM (one-hot or 3-bit), the shift register and the bit counter.

## Test plan
- Reset: hold `reset_n`=0 and toggle `start`. Required: `o_ss_n`=1, `o_sclk`=0, `o_mosi`=0, `busy`=0 throughout.
- Loopback with the POV receiver at HALF=4:
  - Stimulus: playerX=15'h0300, playerY=15'h0300, facingX=11'h000, facingY=11'h200, vplaneX=11'h700, vplaneY=11'h000, then pulse `start`.
  - Required: exactly 74 SCLK rises, and the receiver's ready buffer equals the concatenated 74-bit value.
- Timing check at HALF=2, GAP=2:
  - Required: /SS is low for exactly 298 cycles.
  - Required: `done` pulses once, 301 cycles after `start`.
  - Required: MOSI never changes while SCLK is high.
- Start while busy: pulse `start` again 100 cycles into a frame with different vectors. Required: the frame is unchanged, and only one `done` pulse occurs.
- Back-to-back frames: assert `start` in the `done` cycle with new vectors. Required: /SS is high for exactly GAP+1 cycles, and the second frame arrives intact.
- Reset mid-frame: drop `reset_n` at bit 40. Required: /SS goes high immediately and the receiver's ready buffer is unchanged. A following full frame must then be received correctly.
